// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_if
// Brief    : Bus bundle between the fetch unit, the icache, the FOQ push
//            decoder, the redirect source and the branch-commit BHT updater.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_unit_if;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_data;
    logic        foq_full;
    logic        inst_out_valid;
    logic [31:0] inst_out;
    logic [31:0] addr_out;
    logic        pred_taken_out;
    logic        predict_fail;
    logic [31:0] redirect_pc;
    logic        bht_upd_valid;
    logic [31:0] bht_upd_addr;
    logic        bht_upd_taken;

    modport master (
        output icache_req, icache_addr, inst_out_valid, inst_out, addr_out, pred_taken_out,
        input  icache_ready, icache_data, foq_full, predict_fail, redirect_pc,
               bht_upd_valid, bht_upd_addr, bht_upd_taken
    );

    modport slave (
        input  icache_req, icache_addr, inst_out_valid, inst_out, addr_out, pred_taken_out,
        output icache_ready, icache_data, foq_full, predict_fail, redirect_pc,
               bht_upd_valid, bht_upd_addr, bht_upd_taken
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : Single-outstanding instruction fetch with 2-bit BHT / JAL
//            predecode next-PC prediction and predict_fail redirect.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          BHT_SIZE_W = 6
) (
    input  wire logic           clk_in,
    input  wire logic           rst_in,
    input  wire logic           rdy_in,
    inst_fetch_unit_if.master   bus
);
    localparam int        c_BHT_ENTRIES = 1 << BHT_SIZE_W;
    localparam logic [6:0] c_OP_JAL     = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH  = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state_q,        w_state_d;
    logic [31:0] r_pc_q,           w_pc_d;
    logic        r_icache_req_q,   w_icache_req_d;
    logic [31:0] r_icache_addr_q,  w_icache_addr_d;
    logic        r_inst_valid_q,   w_inst_valid_d;
    logic [31:0] r_inst_out_q,     w_inst_out_d;
    logic [31:0] r_addr_out_q,     w_addr_out_d;
    logic        r_pred_taken_q,   w_pred_taken_d;
    logic [1:0]  r_bht_q [c_BHT_ENTRIES];
    logic [1:0]  w_bht_d [c_BHT_ENTRIES];

    logic [BHT_SIZE_W-1:0] w_bht_idx;
    logic [BHT_SIZE_W-1:0] w_upd_idx;
    logic [1:0]            w_bht_ctr;
    logic [6:0]            w_opcode;
    logic [31:0]           w_j_imm;
    logic [31:0]           w_b_imm;
    logic [31:0]           w_next_pc;
    logic                  w_pred;
    logic                  w_unused_upd_addr;

    assign w_bht_idx = r_pc_q[BHT_SIZE_W+1:2];
    assign w_upd_idx = bus.bht_upd_addr[BHT_SIZE_W+1:2];
    assign w_bht_ctr = r_bht_q[w_bht_idx];
    assign w_opcode  = bus.icache_data[6:0];
    assign w_j_imm   = {{11{bus.icache_data[31]}}, bus.icache_data[31], bus.icache_data[19:12],
                        bus.icache_data[20], bus.icache_data[30:21], 1'b0};
    assign w_b_imm   = {{19{bus.icache_data[31]}}, bus.icache_data[31], bus.icache_data[7],
                        bus.icache_data[30:25], bus.icache_data[11:8], 1'b0};
    assign w_unused_upd_addr = ^{bus.bht_upd_addr[31:BHT_SIZE_W+2], bus.bht_upd_addr[1:0]};

    // Prediction is made from the raw response word while it is on the bus.
    always_comb begin
        w_next_pc = r_pc_q + 32'd4;
        w_pred    = 1'b0;
        if (w_opcode == c_OP_JAL) begin
            w_next_pc = r_pc_q + w_j_imm;
            w_pred    = 1'b1;
        end else if ((w_opcode == c_OP_BRANCH) && w_bht_ctr[1]) begin
            w_next_pc = r_pc_q + w_b_imm;
            w_pred    = 1'b1;
        end
    end

    always_comb begin
        w_state_d       = r_state_q;
        w_pc_d          = r_pc_q;
        w_icache_req_d  = r_icache_req_q;
        w_icache_addr_d = r_icache_addr_q;
        w_inst_valid_d  = 1'b0;
        w_inst_out_d    = r_inst_out_q;
        w_addr_out_d    = r_addr_out_q;
        w_pred_taken_d  = r_pred_taken_q;
        if (bus.predict_fail) begin
            // A request already in flight must still be consumed, hence DROP.
            w_pc_d = bus.redirect_pc;
            if (r_state_q == S_WAIT) begin
                if (bus.icache_ready) begin
                    w_icache_req_d = 1'b0;
                    w_state_d      = S_IDLE;
                end else begin
                    w_state_d      = S_DROP;
                end
            end
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    if (!bus.foq_full && !r_inst_valid_q) begin
                        w_icache_req_d  = 1'b1;
                        w_icache_addr_d = r_pc_q;
                        w_state_d       = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.icache_ready) begin
                        w_icache_req_d = 1'b0;
                        w_inst_valid_d = 1'b1;
                        w_inst_out_d   = bus.icache_data;
                        w_addr_out_d   = r_pc_q;
                        w_pred_taken_d = w_pred;
                        w_pc_d         = w_next_pc;
                        w_state_d      = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (bus.icache_ready) begin
                        w_icache_req_d = 1'b0;
                        w_state_d      = S_IDLE;
                    end
                end
                default: w_state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_bht_d = r_bht_q;
        if (bus.bht_upd_valid) begin
            if (bus.bht_upd_taken && (r_bht_q[w_upd_idx] != 2'b11)) begin
                w_bht_d[w_upd_idx] = r_bht_q[w_upd_idx] + 2'd1;
            end else if (!bus.bht_upd_taken && (r_bht_q[w_upd_idx] != 2'b00)) begin
                w_bht_d[w_upd_idx] = r_bht_q[w_upd_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state_q       <= S_IDLE;
            r_pc_q          <= RESET_PC;
            r_icache_req_q  <= 1'b0;
            r_icache_addr_q <= 32'h0;
            r_inst_valid_q  <= 1'b0;
            r_inst_out_q    <= 32'h0;
            r_addr_out_q    <= 32'h0;
            r_pred_taken_q  <= 1'b0;
            for (int i = 0; i < c_BHT_ENTRIES; i++) begin
                r_bht_q[i] <= 2'b01;
            end
        end else if (rdy_in) begin
            r_state_q       <= w_state_d;
            r_pc_q          <= w_pc_d;
            r_icache_req_q  <= w_icache_req_d;
            r_icache_addr_q <= w_icache_addr_d;
            r_inst_valid_q  <= w_inst_valid_d;
            r_inst_out_q    <= w_inst_out_d;
            r_addr_out_q    <= w_addr_out_d;
            r_pred_taken_q  <= w_pred_taken_d;
            r_bht_q         <= w_bht_d;
        end
    end

    assign bus.icache_req     = r_icache_req_q;
    assign bus.icache_addr    = r_icache_addr_q;
    assign bus.inst_out_valid = r_inst_valid_q;
    assign bus.inst_out       = r_inst_out_q;
    assign bus.addr_out       = r_addr_out_q;
    assign bus.pred_taken_out = r_pred_taken_q;
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Brief    : Directed, table-driven self-checking bench for inst_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;
    logic clk;
    logic rst;
    logic rdy;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(
        .RESET_PC   (32'h0),
        .BHT_SIZE_W (6)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          n_taken;
        int          n_not_taken;
        logic [31:0] exp_next;
        logic        exp_pred;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   strobe_cnt = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.inst_out_valid) begin
            strobe_cnt++;
            check("no_back_to_back_strobe", 32'(prev_valid), 32'h0);
        end
        prev_valid = bus.inst_out_valid;
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        int n = 0;
        while (!bus.icache_req && n < 20) begin
            tick();
            n++;
        end
        check({name, "_req"}, 32'(bus.icache_req), 32'h1);
        check({name, "_addr"}, bus.icache_addr, exp_addr);
    endtask

    task automatic serve(input logic [31:0] data, input int lat);
        for (int i = 1; i < lat; i++) tick();
        bus.icache_ready = 1'b1;
        bus.icache_data  = data;
        tick();
        bus.icache_ready = 1'b0;
        bus.icache_data  = 32'h0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        int s = strobe_cnt;
        bus.predict_fail = 1'b1;
        bus.redirect_pc  = pc;
        tick();
        bus.predict_fail = 1'b0;
        bus.redirect_pc  = 32'h0;
        if (bus.icache_req) begin
            bus.icache_ready = 1'b1;
            bus.icache_data  = 32'h0000006F;
            tick();
            bus.icache_ready = 1'b0;
            bus.icache_data  = 32'h0;
        end
        check("redirect_no_strobe", 32'(strobe_cnt - s), 32'h0);
    endtask

    task automatic apply_vec(input vec_t v);
        for (int i = 0; i < v.n_taken + v.n_not_taken; i++) begin
            bus.bht_upd_valid = 1'b1;
            bus.bht_upd_addr  = v.pc;
            bus.bht_upd_taken = (i < v.n_taken);
            tick();
        end
        bus.bht_upd_valid = 1'b0;
        bus.bht_upd_taken = 1'b0;
        redirect(v.pc);
        wait_req("vec_fetch", v.pc);
        serve(v.inst, 1);
        check("vec_strobe", 32'(bus.inst_out_valid), 32'h1);
        check("vec_addr_out", bus.addr_out, v.pc);
        check("vec_inst_out", bus.inst_out, v.inst);
        check("vec_pred", 32'(bus.pred_taken_out), 32'(v.exp_pred));
        wait_req("vec_next", v.exp_next);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        vecs[0] = '{32'h00000010, 32'h0200006F, 0, 0, 32'h00000030, 1'b1}; // JAL +0x20
        vecs[1] = '{32'h00000040, 32'hFE000CE3, 3, 0, 32'h00000038, 1'b1}; // BEQ -8, trained taken
        vecs[2] = '{32'h00000040, 32'hFE000CE3, 0, 2, 32'h00000044, 1'b0}; // back to weak NT
        vecs[3] = '{32'h00000020, 32'h00008067, 0, 0, 32'h00000024, 1'b0}; // JALR not predicted
        vecs[4] = '{32'h00000080, 32'h00000863, 0, 0, 32'h00000084, 1'b0}; // BEQ +16, fresh entry
        vecs[5] = '{32'h00000080, 32'h00000863, 1, 0, 32'h00000090, 1'b1}; // weakly taken
        vecs[6] = '{32'hFFFFFFFC, 32'h0080006F, 0, 0, 32'h00000004, 1'b1}; // JAL +8 wraps
        vecs[7] = '{32'h00000100, 32'hFFDFF06F, 0, 0, 32'h000000FC, 1'b1}; // JAL -4

        rst = 1'b1;
        rdy = 1'b1;
        bus.icache_ready  = 1'b0;
        bus.icache_data   = 32'h0;
        bus.foq_full      = 1'b0;
        bus.predict_fail  = 1'b0;
        bus.redirect_pc   = 32'h0;
        bus.bht_upd_valid = 1'b0;
        bus.bht_upd_addr  = 32'h0;
        bus.bht_upd_taken = 1'b0;
        tick();
        tick();
        check("rst_req", 32'(bus.icache_req), 32'h0);
        check("rst_icache_addr", bus.icache_addr, 32'h0);
        check("rst_valid", 32'(bus.inst_out_valid), 32'h0);
        check("rst_inst_out", bus.inst_out, 32'h0);
        check("rst_addr_out", bus.addr_out, 32'h0);
        check("rst_pred", 32'(bus.pred_taken_out), 32'h0);
        rst = 1'b0;

        // Sequential NOP fetches, two-cycle icache latency.
        for (int k = 0; k < 3; k++) begin
            wait_req("seq_fetch", 32'(4 * k));
            serve(32'h00000013, 2);
            check("seq_strobe", 32'(bus.inst_out_valid), 32'h1);
            check("seq_addr_out", bus.addr_out, 32'(4 * k));
            check("seq_pred", 32'(bus.pred_taken_out), 32'h0);
        end

        // FOQ full holds off the next request.
        bus.foq_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("foq_full_no_req", 32'(bus.icache_req), 32'h0);
        end
        bus.foq_full = 1'b0;
        tick();
        check("foq_release_req", 32'(bus.icache_req), 32'h1);
        check("foq_release_addr", bus.icache_addr, 32'h0000000C);
        serve(32'h00000013, 1);

        for (int i = 0; i < NV; i++) apply_vec(vecs[i]);

        // Redirect while waiting; late response must be swallowed.
        s = strobe_cnt;
        bus.predict_fail = 1'b1;
        bus.redirect_pc  = 32'h00000100;
        tick();
        bus.predict_fail = 1'b0;
        check("drop_req_held", 32'(bus.icache_req), 32'h1);
        check("drop_addr_held", bus.icache_addr, 32'h000000FC);
        tick();
        tick();
        serve(32'h0200006F, 1);
        check("drop_no_strobe", 32'(strobe_cnt - s), 32'h0);
        wait_req("drop_refetch", 32'h00000100);

        // Redirect in the very cycle the response arrives.
        s = strobe_cnt;
        bus.predict_fail = 1'b1;
        bus.redirect_pc  = 32'h00000100;
        bus.icache_ready = 1'b1;
        bus.icache_data  = 32'h0200006F;
        tick();
        bus.predict_fail = 1'b0;
        bus.icache_ready = 1'b0;
        bus.icache_data  = 32'h0;
        check("same_cycle_req_low", 32'(bus.icache_req), 32'h0);
        wait_req("same_cycle_refetch", 32'h00000100);
        check("same_cycle_no_strobe", 32'(strobe_cnt - s), 32'h0);

        // Freeze mid-WAIT with activity on every input.
        rdy = 1'b0;
        bus.icache_ready = 1'b1;
        bus.icache_data  = 32'h0200006F;
        bus.predict_fail = 1'b1;
        bus.redirect_pc  = 32'h00000200;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("freeze_req", 32'(bus.icache_req), 32'h1);
            check("freeze_addr", bus.icache_addr, 32'h00000100);
            check("freeze_valid", 32'(bus.inst_out_valid), 32'h0);
        end
        rdy = 1'b1;
        bus.icache_ready = 1'b0;
        bus.icache_data  = 32'h0;
        bus.predict_fail = 1'b0;
        bus.redirect_pc  = 32'h0;
        tick();
        check("unfreeze_still_wait", 32'(bus.icache_req), 32'h1);
        check("unfreeze_addr", bus.icache_addr, 32'h00000100);

        // Train 0x40 taken, then reset mid-WAIT must restore weak NT.
        for (int i = 0; i < 3; i++) begin
            bus.bht_upd_valid = 1'b1;
            bus.bht_upd_addr  = 32'h00000040;
            bus.bht_upd_taken = 1'b1;
            tick();
        end
        bus.bht_upd_valid = 1'b0;
        bus.bht_upd_taken = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_req", 32'(bus.icache_req), 32'h0);
        check("midrst_addr", bus.icache_addr, 32'h0);
        wait_req("midrst_fetch", 32'h0);
        apply_vec('{32'h00000040, 32'hFE000CE3, 0, 0, 32'h00000044, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
